// File: rtl/powertrigger_pkg.sv
// powertrigger_pkg
//   Shared types and width helpers for the multi-channel power trigger.
//   - pt_state_e : per-channel trigger FSM states (HOLD is used only when
//                  PT_HYSTERESIS_EN is defined)
//   - pt_pow_w   : instantaneous power width (2*SAMPLE_W)
//   - pt_sum_w   : running window sum width (POW_W + AVG_LOG2)
//   - pt_idx_w   : channel-index width, at least 1 bit
//   - pt_max     : larger of two widths
package powertrigger_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        ARMED = 3'd2,
        FIRED = 3'd3,
        HOLD  = 3'd4
    } pt_state_e;

    function automatic int pt_pow_w(input int sample_w);
        return 2 * sample_w;
    endfunction

    function automatic int pt_sum_w(input int sample_w, input int avg_log2);
        return 2 * sample_w + avg_log2;
    endfunction

    function automatic int pt_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int pt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/powertrigger_channel.sv
// powertrigger_channel
//   One channel of the power trigger: registered I/Q power, sliding-window
//   average and the skip/armed/fired/cooldown FSM.
//   Optional feature macro: PT_HYSTERESIS_EN (adds HOLD state, uses threshold_low).
// Ports:
//   clock, reset     : clock, asynchronous active-low reset
//   enable           : low forces IDLE on the next edge
//   sample_valid     : qualifies sample_i/sample_q
//   sample_i/q       : two's complement I and Q components
//   threshold        : fire level compared with the averaged power
//   threshold_low    : re-arm level (hysteresis build only)
//   cooldown, skip   : counts in valid samples, latched on FSM entry
//   trigger          : registered trigger level
//   trigger_nxt      : value trigger takes at the next edge (for strobe logic)
//   power_avg        : registered averaged power
module powertrigger_channel
    import powertrigger_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int AVG_LOG2 = 2,
    parameter int CNT_W    = 16,
    parameter int SKIP_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_i,
    input  logic [SAMPLE_W-1:0]   sample_q,
    input  logic [2*SAMPLE_W-1:0] threshold,
    input  logic [2*SAMPLE_W-1:0] threshold_low,
    input  logic [CNT_W-1:0]      cooldown,
    input  logic [SKIP_W-1:0]     skip,
    output logic                  trigger,
    output logic                  trigger_nxt,
    output logic [2*SAMPLE_W-1:0] power_avg
);

    localparam int POW_W = pt_pow_w(SAMPLE_W);
    localparam int SUM_W = pt_sum_w(SAMPLE_W, AVG_LOG2);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int CW    = pt_max(CNT_W, SKIP_W);

    // Stage 1: power. Sign-extend before squaring; (-2^(W-1))^2 fits as a positive value.
    logic signed [POW_W-1:0] i_ext, q_ext;
    logic [POW_W-1:0]        pow_new, p1;
    logic                    v1;

    assign i_ext   = POW_W'($signed(sample_i));
    assign q_ext   = POW_W'($signed(sample_q));
    assign pow_new = $unsigned(i_ext * i_ext) + $unsigned(q_ext * q_ext);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= sample_valid;
            if (sample_valid) p1 <= pow_new;
        end
    end

    // Stage 2: window kept as a packed shift line; the oldest entry sits at the top.
    logic [DEPTH*POW_W-1:0] win;
    logic [POW_W-1:0]       oldest;
    logic [SUM_W-1:0]       sum, sum_nxt;
    logic                   v2;

    assign oldest  = win[(DEPTH-1)*POW_W +: POW_W];
    assign sum_nxt = sum + SUM_W'(p1) - SUM_W'(oldest);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win       <= '0;
            sum       <= '0;
            power_avg <= '0;
            v2        <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                win       <= (win << POW_W) | (DEPTH*POW_W)'(p1);
                sum       <= sum_nxt;
                power_avg <= sum_nxt[AVG_LOG2 +: POW_W];
            end
        end
    end

    // Stage 3: FSM.
    pt_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

`ifndef PT_HYSTERESIS_EN
    logic unused_threshold_low;
    assign unused_threshold_low = ^threshold_low;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (skip == '0) begin
                        state_nxt = ARMED;
                    end else begin
                        state_nxt = SKIP;
                        cnt_nxt   = CW'(skip);
                    end
                end
                SKIP: begin
                    if (v2) begin
                        if (cnt == CW'(1)) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - CW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (v2 && (power_avg >= threshold)) begin
                        state_nxt = FIRED;
                        cnt_nxt   = (cooldown == '0) ? CW'(1) : CW'(cooldown);
                    end
                end
                FIRED: begin
                    if (v2) begin
                        if (cnt == CW'(1)) begin
`ifdef PT_HYSTERESIS_EN
                            state_nxt = HOLD;
`else
                            state_nxt = ARMED;
`endif
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt - CW'(1);
                        end
                    end
                end
`ifdef PT_HYSTERESIS_EN
                HOLD: begin
                    if (v2 && (power_avg < threshold_low)) state_nxt = ARMED;
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign trigger_nxt = (state_nxt == FIRED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            trigger <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            trigger <= trigger_nxt;
        end
    end

endmodule

// File: rtl/powertrigger_mc.sv
// powertrigger_mc
//   Multi-channel power trigger: N_CH independent channels plus a common
//   registered strobe and lowest-index priority encoder over rising triggers.
//   Optional feature macro: PT_HYSTERESIS_EN (per-channel HOLD after FIRED,
//   re-arm when averaged power drops below threshold_low).
// Ports:
//   clock, reset   : clock, asynchronous active-low reset
//   enable         : low forces all channels to IDLE
//   sample_valid   : qualifies sample, common to all channels
//   sample         : per channel {Q,I}, channel 0 in the LSBs
//   threshold      : fire level; threshold_low : re-arm level (hysteresis)
//   cooldown, skip : trigger length / arming delay in valid samples
//   trigger        : per-channel trigger level
//   trigger_stb    : one-cycle pulse when any channel rises
//   trigger_first  : lowest rising channel index, 0 when no rise
//   power_avg      : per-channel averaged power
module powertrigger_mc
    import powertrigger_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int SAMPLE_W = 16,
    parameter int AVG_LOG2 = 2,
    parameter int CNT_W    = 16,
    parameter int SKIP_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic [N_CH*2*SAMPLE_W-1:0]   sample,
    input  logic [2*SAMPLE_W-1:0]        threshold,
    input  logic [2*SAMPLE_W-1:0]        threshold_low,
    input  logic [CNT_W-1:0]             cooldown,
    input  logic [SKIP_W-1:0]            skip,
    output logic [N_CH-1:0]              trigger,
    output logic                         trigger_stb,
    output logic [pt_idx_w(N_CH)-1:0]    trigger_first,
    output logic [N_CH*2*SAMPLE_W-1:0]   power_avg
);

    localparam int POW_W = pt_pow_w(SAMPLE_W);
    localparam int IDX_W = pt_idx_w(N_CH);

    logic [N_CH-1:0] trig_nxt;
    logic [N_CH-1:0] rise;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        powertrigger_channel #(
            .SAMPLE_W (SAMPLE_W),
            .AVG_LOG2 (AVG_LOG2),
            .CNT_W    (CNT_W),
            .SKIP_W   (SKIP_W)
        ) u_channel (
            .clock         (clock),
            .reset         (reset),
            .enable        (enable),
            .sample_valid  (sample_valid),
            .sample_i      (sample[c*POW_W +: SAMPLE_W]),
            .sample_q      (sample[c*POW_W + SAMPLE_W +: SAMPLE_W]),
            .threshold     (threshold),
            .threshold_low (threshold_low),
            .cooldown      (cooldown),
            .skip          (skip),
            .trigger       (trigger[c]),
            .trigger_nxt   (trig_nxt[c]),
            .power_avg     (power_avg[c*POW_W +: POW_W])
        );
    end

    // Rising edges are taken from the next-state triggers so the strobe lines up with trigger.
    assign rise = trig_nxt & ~trigger;

    logic [IDX_W-1:0] first_nxt;
    logic             found;

    always_comb begin
        first_nxt = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rise[i] && !found) begin
                first_nxt = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trigger_stb   <= 1'b0;
            trigger_first <= '0;
        end else begin
            trigger_stb   <= |rise;
            trigger_first <= first_nxt;
        end
    end

endmodule

// File: tb/tb_powertrigger_mc.sv
// tb_powertrigger_mc
//   Directed and randomized stimulus for powertrigger_mc, checked every clock
//   against a sample-level reference model. Honors PT_HYSTERESIS_EN.
module tb_powertrigger_mc;

    localparam int N_CH     = 2;
    localparam int SAMPLE_W = 16;
    localparam int AVG_LOG2 = 2;
    localparam int CNT_W    = 16;
    localparam int SKIP_W   = 32;
    localparam int SW       = 2 * SAMPLE_W;
    localparam int IDX_W    = 1;
    localparam int DEPTH    = 1 << AVG_LOG2;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic                 sample_valid;
    logic [N_CH*SW-1:0]   sample;
    logic [SW-1:0]        threshold;
    logic [SW-1:0]        threshold_low;
    logic [CNT_W-1:0]     cooldown;
    logic [SKIP_W-1:0]    skip;
    logic [N_CH-1:0]      trigger;
    logic                 trigger_stb;
    logic [IDX_W-1:0]     trigger_first;
    logic [N_CH*SW-1:0]   power_avg;

    powertrigger_mc #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .AVG_LOG2 (AVG_LOG2),
        .CNT_W    (CNT_W),
        .SKIP_W   (SKIP_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .threshold     (threshold),
        .threshold_low (threshold_low),
        .cooldown      (cooldown),
        .skip          (skip),
        .trigger       (trigger),
        .trigger_stb   (trigger_stb),
        .trigger_first (trigger_first),
        .power_avg     (power_avg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model, stepped once per clock edge.
    longint win   [N_CH][DEPTH];
    longint avgm  [N_CH];
    longint p1m   [N_CH];
    bit     v1m, v2m;
    bit     m_idle   [N_CH];
    longint skip_rem [N_CH];
    longint fire_rem [N_CH];
    bit     m_hold   [N_CH];
    bit     m_trig   [N_CH];
    bit     e_stb;
    int     e_first;

    function automatic longint pw(input int c);
        longint i, q;
        i = longint'($signed(sample[c*SW +: SAMPLE_W]));
        q = longint'($signed(sample[c*SW + SAMPLE_W +: SAMPLE_W]));
        return i * i + q * q;
    endfunction

    task automatic set_iq(input int c, input int i, input int q);
        sample[c*SW +: SAMPLE_W]            = SAMPLE_W'(i);
        sample[c*SW + SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(q);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < DEPTH; k++) win[c][k] = 0;
            avgm[c] = 0; p1m[c] = 0;
            m_idle[c] = 1'b1; skip_rem[c] = 0; fire_rem[c] = 0;
            m_hold[c] = 1'b0; m_trig[c] = 1'b0;
        end
        v1m = 1'b0; v2m = 1'b0; e_stb = 1'b0; e_first = 0;
    endtask

    task automatic model_edge();
        bit rose;
        rose = 1'b0;
        e_first = 0;
        // Decision for the sample that entered two edges ago, using the current average.
        for (int c = 0; c < N_CH; c++) begin
            bit was;
            was = m_trig[c];
            if (!enable) begin
                m_idle[c] = 1'b1; skip_rem[c] = 0; fire_rem[c] = 0; m_hold[c] = 1'b0;
            end else if (m_idle[c]) begin
                m_idle[c] = 1'b0;
                skip_rem[c] = longint'(skip);
            end else if (v2m) begin
                if (skip_rem[c] > 0) begin
                    skip_rem[c]--;
                end else if (fire_rem[c] > 0) begin
                    fire_rem[c]--;
`ifdef PT_HYSTERESIS_EN
                    if (fire_rem[c] == 0) m_hold[c] = 1'b1;
`endif
                end else if (m_hold[c]) begin
                    if (avgm[c] < longint'(threshold_low)) m_hold[c] = 1'b0;
                end else if (avgm[c] >= longint'(threshold)) begin
                    fire_rem[c] = (cooldown == '0) ? 1 : longint'(cooldown);
                end
            end
            m_trig[c] = (fire_rem[c] > 0);
            if (m_trig[c] && !was && !rose) begin
                rose = 1'b1;
                e_first = c;
            end
        end
        e_stb = rose;
        if (v1m) begin
            for (int c = 0; c < N_CH; c++) begin
                longint s;
                for (int k = DEPTH - 1; k > 0; k--) win[c][k] = win[c][k-1];
                win[c][0] = p1m[c];
                s = 0;
                for (int k = 0; k < DEPTH; k++) s += win[c][k];
                avgm[c] = s / DEPTH;
            end
        end
        v2m = v1m;
        v1m = sample_valid;
        if (sample_valid) for (int c = 0; c < N_CH; c++) p1m[c] = pw(c);
    endtask

    task automatic check_outputs();
        logic [N_CH-1:0]    et;
        logic [N_CH*SW-1:0] ea;
        for (int c = 0; c < N_CH; c++) begin
            et[c] = m_trig[c];
            ea[c*SW +: SW] = SW'(avgm[c]);
        end
        chk("trigger", 64'(trigger), 64'(et));
        chk("trigger_stb", 64'(trigger_stb), 64'(e_stb));
        chk("trigger_first", 64'(trigger_first), 64'(e_first));
        chk("power_avg", 64'(power_avg), 64'(ea));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_trigger", 64'(trigger), '0);
        chk("rst_stb", 64'(trigger_stb), '0);
        chk("rst_first", 64'(trigger_first), '0);
        chk("rst_avg", 64'(power_avg), '0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int rise_at, high, stbs, rises;
    int sk_tab [3] = '{0, 5, 1};
    int ex_tab [3] = '{2, 7, 3};

    initial begin
        enable = 1'b0; sample_valid = 1'b0; sample = '0;
        threshold = 100; threshold_low = 50; cooldown = 80; skip = 0;
        do_reset();

        // Constant P=100 on channel 0 from reset: fires at the 4th sample, 80 samples high.
        set_iq(0, 10, 0);
        sample_valid = 1'b1; enable = 1'b1;
        rise_at = -1; high = 0; stbs = 0;
        for (int n = 1; n <= 86; n++) begin
            tick();
            if (trigger[0]) begin
                high++;
                if (rise_at < 0) rise_at = n;
            end
            if (trigger_stb) begin
                stbs++;
                chk("t1_first", 64'(trigger_first), 0);
            end
        end
        chk("t1_rise_edge", 64'(rise_at), 6);
        chk("t1_high_len", 64'(high), 80);
        chk("t1_stb_count", 64'(stbs), 1);
        tick();
        chk("t1_refire", 64'(trigger[0]), 1);

        // Skip delay measured with the window already full.
        for (int t = 0; t < 3; t++) begin
            enable = 1'b0; sample_valid = 1'b0;
            do_reset();
            skip = SKIP_W'(sk_tab[t]);
            set_iq(0, 10, 0);
            sample_valid = 1'b1;
            repeat (8) tick();
            enable = 1'b1;
            rise_at = -1;
            for (int n = 1; n <= 12; n++) begin
                tick();
                if (trigger[0] && rise_at < 0) rise_at = n;
            end
            chk("t2_skip_rise", 64'(rise_at), 64'(ex_tab[t]));
        end
        skip = 0;

        // Simultaneous rise on both channels, then channel 1 alone.
        for (int t = 0; t < 2; t++) begin
            enable = 1'b0; sample_valid = 1'b0;
            do_reset();
            set_iq(0, (t == 0) ? 10 : 0, 0);
            set_iq(1, 0, 10);
            sample_valid = 1'b1; enable = 1'b1;
            stbs = 0;
            for (int n = 1; n <= 10; n++) begin
                tick();
                if (trigger_stb) begin
                    stbs++;
                    chk("t3_trigger", 64'(trigger), (t == 0) ? 64'd3 : 64'd2);
                    chk("t3_first", 64'(trigger_first), (t == 0) ? 64'd0 : 64'd1);
                end
            end
            chk("t3_stb_count", 64'(stbs), 1);
        end

        // Valid every other clock: latency and cooldown count in valid samples.
        enable = 1'b0; sample_valid = 1'b0;
        do_reset();
        set_iq(0, 10, 0); set_iq(1, 0, 0);
        enable = 1'b1;
        rise_at = -1; high = 0;
        for (int n = 1; n <= 169; n++) begin
            sample_valid = n[0];
            tick();
            if (trigger[0]) begin
                high++;
                if (rise_at < 0) rise_at = n;
            end
        end
        chk("t4_rise_edge", 64'(rise_at), 9);
        chk("t4_high_len", 64'(high), 160);
        chk("t4_avg", 64'(power_avg[SW-1:0]), 100);

        // Full-scale negative samples, enable drop mid-FIRED, reset mid-SKIP.
        enable = 1'b0; sample_valid = 1'b0;
        do_reset();
        set_iq(0, -32768, -32768); set_iq(1, -32768, -32768);
        sample_valid = 1'b1; enable = 1'b1;
        repeat (8) tick();
        chk("t5_avg_max", 64'(power_avg[SW-1:0]), 64'h8000_0000);
        chk("t5_fired", 64'(trigger), 3);
        enable = 1'b0;
        tick();
        chk("t5_enable_drop", 64'(trigger), 0);
        enable = 1'b1; skip = 20;
        repeat (5) tick();
        do_reset();
        skip = 0;

`ifdef PT_HYSTERESIS_EN
        // Sustained burst fires once; dropping below threshold_low re-arms.
        enable = 1'b0; sample_valid = 1'b0;
        do_reset();
        threshold = 100; threshold_low = 50; cooldown = 10;
        set_iq(0, 10, 0); set_iq(1, 0, 0);
        sample_valid = 1'b1; enable = 1'b1;
        rises = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (trigger_stb) rises++;
        end
        chk("t6_one_fire", 64'(rises), 1);
        set_iq(0, 3, 1);
        repeat (4) begin
            tick();
            if (trigger_stb) rises++;
        end
        set_iq(0, 10, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (trigger_stb) rises++;
        end
        chk("t6_second_fire", 64'(rises), 2);
`endif

        // Randomized traffic around the threshold.
        enable = 1'b0; sample_valid = 1'b0;
        do_reset();
        threshold = 100; threshold_low = 50; cooldown = 3; skip = 1;
        enable = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (n % 64 == 0) begin
                threshold     = SW'($urandom_range(40, 200));
                threshold_low = SW'($urandom_range(20, 100));
                cooldown      = CNT_W'($urandom_range(0, 6));
                skip          = SKIP_W'($urandom_range(0, 3));
            end
            if (n == 700) do_reset();
            enable = ($urandom_range(0, 99) < 97);
            sample_valid = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N_CH; c++)
                set_iq(c, int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 24)) - 12);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/powertrigger_mc.md
Name: powertrigger_mc

Overview:
Parametrised multi-channel successor to the single-channel power trigger. It computes per-channel instantaneous I/Q power and a sliding-window average. Each channel runs its own skip/armed/fired/cooldown FSM against a runtime threshold. It sits directly after the I/Q sample source and raises per-channel trigger strobes for packet-detection logic downstream.

Parameters:
N_CH, 2, number of parallel I/Q channels
SAMPLE_W, 16, signed width of each I and Q component
AVG_LOG2, 2, log2 of the averaging window length in samples (window = 2^AVG_LOG2, minimum 0)
CNT_W, 16, width of the cooldown counter
SKIP_W, 32, width of the skip counter

Ports:
clock  in  1  system clock; one valid sample per clock maximum
reset  in  1  asynchronous, active-low reset
enable  in  1  low forces all channels to IDLE
sample_valid  in  1  qualifies sample; common to all channels
sample  in  N_CH*2*SAMPLE_W  per channel {Q,I}, channel 0 in the LSBs, two's complement
threshold  in  2*SAMPLE_W  fire level, compared against the averaged power
threshold_low  in  2*SAMPLE_W  re-arm level; used only with PT_HYSTERESIS_EN
cooldown  in  CNT_W  valid samples for which trigger stays high
skip  in  SKIP_W  valid samples ignored after enable before arming
trigger  out  N_CH  per-channel trigger level
trigger_stb  out  1  one-cycle pulse when any channel rises this cycle
trigger_first  out  max(1,$clog2(N_CH))  lowest channel index rising this cycle; 0 when trigger_stb is low
power_avg  out  N_CH*2*SAMPLE_W  per-channel averaged power for monitoring

Behaviour:
- Reset: all outputs 0. Window buffers and running sums are 0. FSMs are in IDLE.
- Power: P = I*I + Q*Q, unsigned, width POW_W = 2*SAMPLE_W. The maximum (-2^(W-1) on both I and Q) gives 2^(2W-1), so P never overflows.
- Average: ring buffer of 2^AVG_LOG2 powers plus a running sum of width POW_W+AVG_LOG2. Per valid sample: sum += P_new - P_oldest. avg = sum >> AVG_LOG2 (truncating). The buffer starts at zero, so the average ramps up during the first window.
- Pipeline: stage 1 registers P; stage 2 updates the sum and avg; stage 3 runs the FSM and registers trigger. A crossing sample presented at edge k gives trigger high after edge k+3. Stages advance only for valid samples, with valid flags carried through; bubbles do not advance the window or any counter.
- threshold and threshold_low are read live on every stage-3 valid cycle. cooldown is latched on entry to FIRED; skip is latched on leaving IDLE.
- FSM per channel, IDLE/SKIP/ARMED/FIRED[/HOLD]:
  - IDLE: when enable=1, go to SKIP with cnt=skip. If skip=0, go directly to ARMED.
  - SKIP: decrement cnt per valid stage-3 sample; at cnt==1 go to ARMED.
  - ARMED: on a valid sample with avg >= threshold, go to FIRED with cnt=cooldown (cooldown=0 treated as 1). trigger rises.
  - FIRED: trigger=1. Decrement cnt per valid sample; at cnt==1 go to ARMED (HOLD with the macro). The sample that ends FIRED is not evaluated for a new fire; the earliest re-fire is on the next valid sample.
- enable=0 in any state: next edge goes to IDLE, trigger drops, cnt clears. The window and sum are kept and keep updating on valid samples.
- Reset mid-operation clears everything asynchronously; no trigger glitch is permitted after deassertion.
- trigger_stb/trigger_first: registered together with trigger, from the per-channel rising edges. If several channels rise in the same cycle, the lowest index wins.

Optional Feature:
PT_HYSTERESIS_EN
- Defined: after FIRED, the channel enters HOLD with trigger=0. It returns to ARMED only on a valid sample with avg < threshold_low. This blocks retriggering on a sustained burst.
- Undefined: there is no HOLD state and threshold_low is ignored. FIRED returns to ARMED immediately.

Decomposition:
- Package powertrigger_pkg holds the FSM state enum (IDLE, SKIP, ARMED, FIRED, HOLD) and localparam helpers: POW_W = 2*SAMPLE_W, SUM_W = POW_W+AVG_LOG2, and the channel-index width.
- Sub-module powertrigger_channel contains the power, window and FSM for a single channel. The top instantiates N_CH of them with generate and adds the strobe/priority-encode logic.

Test Plan:
1. Ch0 constant I=10, Q=0 (P=100), threshold=100, cooldown=80, skip=0, AVG_LOG2=2 -> avg reaches 100 on the 4th sample. trigger[0] rises 3 clocks later and stays high exactly 80 valid samples. trigger_stb pulses once with trigger_first=0.
2. skip=5, same stimulus -> trigger delayed by 5 valid samples versus case 1. skip=1 -> delayed by 1.
3. Ch0 and ch1 cross on the same sample -> trigger=2'b11, trigger_stb=1, trigger_first=0. Ch1 alone -> trigger_first=1.
4. sample_valid toggled 1/0 every clock -> all latencies and the cooldown count are measured in valid samples only. Power values are unchanged.
5. I=Q=-32768 -> P=2^31 and avg=2^31 with no wrap. Drop enable mid-FIRED -> trigger low next edge. Assert reset mid-SKIP -> all outputs 0 asynchronously.
6. With PT_HYSTERESIS_EN, threshold=100, threshold_low=50, sustained P=100 -> one fire only. Then P=10 for 4 samples, then P=100 -> second fire.
